lfsr_seq_checker: RTL and testbench
===================================

// Module: lfsr_seq_checker
// PURPOSE
//   Downstream consumer of the 4-bit LFSR generator: samples the LFSR output stream,
//   self-synchronises to it, then flags and counts every sample that breaks the sequence.
//   Sits at the receive end of a link/BIST path; its lock and error outputs feed status regs.
//   Next-state function (fixed, identical to generator): nxt(s) = {s[2:0], s[1]^s[3]}.
//   Seed 4'h1 gives period-6 cycle 1,2,5,A,4,8,1...; 4'h0 is the lock-up state.
// PARAMETERS
//   LOCK_CNT    4  consecutive matches required in HUNT to declare lock (>=1)
//   ERR_THRESH  3  consecutive mismatches in LOCKED that drop lock (>=1)
//   ERR_CNT_W   8  width of saturating error counter
// PORTS
//   clk          in   1          rising-edge clock (only clock)
//   reset        in   1          synchronous, active-high reset
//   data_valid_i in   1          data_i carries a new sample this cycle
//   data_i       in   4          LFSR sample under test
//   clear_i      in   1          synchronous clear of err_count_o
//   locked_o     out  1          checker synchronised to stream
//   error_o      out  1          1-cycle pulse: previous valid sample mismatched (LOCKED only)
//   err_count_o  out  ERR_CNT_W  saturating count of mismatches seen while LOCKED
// BEHAVIOUR
//   Reset: state=HUNT, locked_o=0, error_o=0, err_count_o=0, match/consec-err ctrs=0, have_prev=0.
//   Reset wins over every other input; reset mid-lock drops locked_o on next edge.
//   Cycles with data_valid_i=0: no state, counter or expectation change; error_o=0.
//   All outputs registered; error_o/locked_o/err_count_o update edge after the valid sample.
//   HUNT:
//     - first valid sample after entry: seed prev=data_i, have_prev=1, no compare.
//     - later valid samples: match iff data_i==nxt(prev) and data_i!=0; match -> match_cnt++,
//       mismatch -> match_cnt=0; prev=data_i always (re-seed).
//     - data_i==0 never matches and is not accepted as a seed (have_prev stays/ becomes 0).
//     - match_cnt reaching LOCK_CNT -> LOCKED; expected=nxt(data_i); consec_err=0.
//     - no errors counted and error_o never pulses in HUNT.
//   LOCKED (flywheel):
//     - each valid sample compared to expected; expected=nxt(expected) regardless of result
//       (single corrupted sample does not shift the reference).
//     - match: consec_err=0.
//     - mismatch (incl. data_i==0): error_o=1 next cycle, err_count_o+1, consec_err+1.
//     - consec_err reaching ERR_THRESH -> HUNT, match_cnt=0, have_prev=0, locked_o=0.
//   err_count_o: saturates at all-ones, never wraps.
//     clear_i alone -> 0; clear_i with simultaneous increment -> 1 (error not lost).
//   locked_o=1 exactly while state=LOCKED.
// TESTING
//   1. reset held 2 cycles, valid toggling -> locked_o=0, error_o=0, err_count_o=0.
//   2. from reset feed 1,2,5,A,4 back-to-back -> locked_o rises edge after 4th match (0x4), err_count_o=0.
//   3. locked; feed 8,F,2 (F replaces expected 1) -> one error_o pulse, err_count_o=1, locked_o stays 1.
//   4. locked; feed 0,0,0 -> err_count_o+=3, locked_o falls after 3rd; then 5 clean samples -> relock.
//   5. locked; valid low 5 cycles between 2 and 5 -> no errors; same-cycle clear_i+error -> err_count_o=1.
//   6. ERR_CNT_W=2, locked, 6 mismatches w/ ERR_THRESH=8 -> err_count_o holds 3; reset mid-LOCKED -> all outputs 0.

Source files
------------

// File: rtl/lfsr_seq_checker.sv
// lfsr_seq_checker
//   Receive-side checker for the 4-bit LFSR stream. The generator's next-state
//   function is nxt(s) = {s[2:0], s[1]^s[3]}. In HUNT the checker looks for
//   LOCK_CNT back-to-back correct successors before it declares lock. Once
//   LOCKED it runs a flywheel reference and flags every sample that differs from
//   it. ERR_THRESH consecutive misses drop it back to HUNT.
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   data_valid_i data_i carries a new sample this cycle
//   data_i       LFSR sample under test
//   clear_i      synchronous clear of err_count_o
//   locked_o     checker synchronised to the stream
//   error_o      1-cycle pulse: the previous valid sample mismatched (LOCKED only)
//   err_count_o  saturating count of mismatches seen while LOCKED
module lfsr_seq_checker #(
  parameter int LOCK_CNT   = 4,
  parameter int ERR_THRESH = 3,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 data_valid_i,
  input  logic [3:0]           data_i,
  input  logic                 clear_i,
  output logic                 locked_o,
  output logic                 error_o,
  output logic [ERR_CNT_W-1:0] err_count_o
);
  localparam int MC_W = $clog2(LOCK_CNT + 1);
  localparam int CE_W = $clog2(ERR_THRESH + 1);
  localparam logic [MC_W-1:0] MC_LAST = MC_W'(LOCK_CNT - 1);
  localparam logic [CE_W-1:0] CE_LAST = CE_W'(ERR_THRESH - 1);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  function automatic logic [3:0] nxt(input logic [3:0] s);
    return {s[2:0], s[1] ^ s[3]};
  endfunction

  state_t               state, state_n;
  logic [3:0]           prev, prev_n;
  logic                 have_prev, have_prev_n;
  logic [MC_W-1:0]      match_cnt, match_cnt_n;
  logic [3:0]           expected, expected_n;
  logic [CE_W-1:0]      consec, consec_n;
  logic [ERR_CNT_W-1:0] cnt_n;
  logic                 err_n, inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HUNT;
      prev        <= '0;
      have_prev   <= 1'b0;
      match_cnt   <= '0;
      expected    <= '0;
      consec      <= '0;
      error_o     <= 1'b0;
      err_count_o <= '0;
    end else begin
      state       <= state_n;
      prev        <= prev_n;
      have_prev   <= have_prev_n;
      match_cnt   <= match_cnt_n;
      expected    <= expected_n;
      consec      <= consec_n;
      error_o     <= err_n;
      err_count_o <= cnt_n;
    end
  end

  // state is itself a register, so locked_o stays registered
  assign locked_o = (state == LOCKED);

  always_comb begin
    state_n     = state;
    prev_n      = prev;
    have_prev_n = have_prev;
    match_cnt_n = match_cnt;
    expected_n  = expected;
    consec_n    = consec;
    err_n       = 1'b0;
    inc         = 1'b0;
    if (data_valid_i) begin
      case (state)
        HUNT: begin
          if (data_i == 4'h0) begin
            // lock-up value: never a valid seed or successor
            have_prev_n = 1'b0;
            match_cnt_n = '0;
          end else if (!have_prev) begin
            prev_n      = data_i;
            have_prev_n = 1'b1;
          end else begin
            prev_n = data_i;
            if (data_i == nxt(prev)) begin
              if (match_cnt == MC_LAST) begin
                state_n     = LOCKED;
                expected_n  = nxt(data_i);
                consec_n    = '0;
                match_cnt_n = '0;
              end else begin
                match_cnt_n = match_cnt + 1'b1;
              end
            end else begin
              match_cnt_n = '0;
            end
          end
        end
        LOCKED: begin
          // Flywheel: the reference advances whether or not the sample matched.
          expected_n = nxt(expected);
          if (data_i == expected) begin
            consec_n = '0;
          end else begin
            inc   = 1'b1;
            err_n = 1'b1;
            if (consec == CE_LAST) begin
              state_n     = HUNT;
              match_cnt_n = '0;
              have_prev_n = 1'b0;
              consec_n    = '0;
            end else begin
              consec_n = consec + 1'b1;
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end
    // A clear in the same cycle as an error leaves that error counted.
    if (clear_i)
      cnt_n = inc ? ERR_CNT_W'(1) : '0;
    else if (inc && !(&err_count_o))
      cnt_n = err_count_o + 1'b1;
    else
      cnt_n = err_count_o;
  end
endmodule

// File: tb/tb_lfsr_seq_checker.sv
module tb_lfsr_seq_checker;
  logic       clk = 1'b0;
  logic       reset;
  logic       data_valid_i;
  logic [3:0] data_i;
  logic       clear_i;
  logic       locked_o, error_o;
  logic [7:0] err_count_o;
  logic       locked2, error2;
  logic [1:0] cnt2;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lfsr_seq_checker dut (
    .clk(clk), .reset(reset), .data_valid_i(data_valid_i), .data_i(data_i),
    .clear_i(clear_i), .locked_o(locked_o), .error_o(error_o), .err_count_o(err_count_o)
  );

  lfsr_seq_checker #(.LOCK_CNT(4), .ERR_THRESH(8), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .data_valid_i(data_valid_i), .data_i(data_i),
    .clear_i(clear_i), .locked_o(locked2), .error_o(error2), .err_count_o(cnt2)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // drive one cycle's inputs at the falling edge; return just after the rising edge
  task automatic cyc(input logic v, input logic [3:0] d, input logic c);
    @(negedge clk);
    data_valid_i = v;
    data_i       = d;
    clear_i      = c;
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic l, input logic e, input logic [7:0] n);
    check({tag, ".locked"}, locked_o, l);
    check({tag, ".error"},  error_o,  e);
    check({tag, ".count"},  err_count_o, n);
  endtask

  initial begin
    reset = 1'b1; data_valid_i = 1'b0; data_i = 4'h0; clear_i = 1'b0;
    // 1: reset held with valid toggling
    cyc(1'b1, 4'h1, 1'b0); outs("rst0", 1'b0, 1'b0, 8'd0);
    cyc(1'b0, 4'h2, 1'b0); outs("rst1", 1'b0, 1'b0, 8'd0);
    reset = 1'b0;

    // 2: acquire lock on 1,2,5,A,4
    cyc(1'b1, 4'h1, 1'b0); outs("seed", 1'b0, 1'b0, 8'd0);
    cyc(1'b1, 4'h2, 1'b0); check("m1.locked", locked_o, 1'b0);
    cyc(1'b1, 4'h5, 1'b0); check("m2.locked", locked_o, 1'b0);
    cyc(1'b1, 4'hA, 1'b0); check("m3.locked", locked_o, 1'b0);
    cyc(1'b1, 4'h4, 1'b0); outs("lock", 1'b1, 1'b0, 8'd0);

    // 3: single corrupted sample (F instead of 1)
    cyc(1'b1, 4'h8, 1'b0); outs("t3a", 1'b1, 1'b0, 8'd0);
    cyc(1'b1, 4'hF, 1'b0); outs("t3b", 1'b1, 1'b1, 8'd1);
    cyc(1'b1, 4'h2, 1'b0); outs("t3c", 1'b1, 1'b0, 8'd1);

    // 4: three zeros lose lock, then relock
    cyc(1'b1, 4'h0, 1'b0); outs("t4a", 1'b1, 1'b1, 8'd2);
    cyc(1'b1, 4'h0, 1'b0); outs("t4b", 1'b1, 1'b1, 8'd3);
    cyc(1'b1, 4'h0, 1'b0); outs("t4c", 1'b0, 1'b1, 8'd4);
    cyc(1'b1, 4'h1, 1'b0); outs("t4seed", 1'b0, 1'b0, 8'd4);
    cyc(1'b1, 4'h2, 1'b0);
    cyc(1'b1, 4'h5, 1'b0);
    cyc(1'b1, 4'hA, 1'b0); check("t4pre.locked", locked_o, 1'b0);
    cyc(1'b1, 4'h4, 1'b0); outs("relock", 1'b1, 1'b0, 8'd4);

    // 5: idle gap between 2 and 5, then clear with simultaneous error
    cyc(1'b1, 4'h8, 1'b0);
    cyc(1'b1, 4'h1, 1'b0);
    cyc(1'b1, 4'h2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 4'h7, 1'b0);
      check("gap.error", error_o, 1'b0);
    end
    cyc(1'b1, 4'h5, 1'b0); outs("t5a", 1'b1, 1'b0, 8'd4);
    cyc(1'b1, 4'hA, 1'b0); outs("t5b", 1'b1, 1'b0, 8'd4);
    cyc(1'b1, 4'h7, 1'b1); outs("clr+err", 1'b1, 1'b1, 8'd1);
    cyc(1'b0, 4'h0, 1'b1); outs("clr", 1'b1, 1'b0, 8'd0);

    // 6: saturation on the 2-bit counter, then reset mid-lock
    reset = 1'b1;
    cyc(1'b0, 4'h0, 1'b0);
    reset = 1'b0;
    cyc(1'b1, 4'h1, 1'b0);
    cyc(1'b1, 4'h2, 1'b0);
    cyc(1'b1, 4'h5, 1'b0);
    cyc(1'b1, 4'hA, 1'b0);
    cyc(1'b1, 4'h4, 1'b0); check("d2.lock", locked2, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b1, 4'h0, 1'b0);
    check("d2.sat", cnt2, 2'd3);
    check("d2.locked", locked2, 1'b1);
    check("d2.error", error2, 1'b1);
    check("d1.unlocked", locked_o, 1'b0);
    check("d1.count", err_count_o, 8'd3);
    reset = 1'b1;
    cyc(1'b1, 4'h0, 1'b0);
    check("d2rst.locked", locked2, 1'b0);
    check("d2rst.error", error2, 1'b0);
    check("d2rst.count", cnt2, 2'd0);
    outs("d1rst", 1'b0, 1'b0, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
